// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: opcode encodings.
package pc_seq_pkg;

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_JMP    = 3'b001;
    localparam logic [2:0] OP_BR_REL = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_HOLD   = 3'b101;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; refuses pushes when full and pops when empty.
module ret_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [SP_W-1:0]  sp,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_sp == SP_W'(DEPTH));
    assign empty     = (r_sp == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !push;
    assign w_wr_idx  = IDX_W'(r_sp);
    assign w_rd_idx  = IDX_W'(r_sp - 1'b1);
    assign top       = empty ? '0 : r_mem[w_rd_idx];
    assign sp        = r_sp;

    // NOTE: storage has no reset; entries above sp are never read, so only sp needs clearing.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with jump, relative branch, CALL/RET stack, stall and sticky stack errors.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter  int PC_WIDTH     = 8,
    parameter  int STACK_DEPTH  = 4,
    parameter  int RESET_VECTOR = 0,
    parameter  int INC_STEP     = 1,
    localparam int SP_W         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0]          op,
    input  logic [PC_WIDTH-1:0] target,
    input  logic [PC_WIDTH-1:0] offset,
    input  logic                err_clr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] ret_addr,
    output logic [SP_W-1:0]     sp,
    output logic                stk_full,
    output logic                stk_empty,
    output logic                ovf_err,
    output logic                unf_err
);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_ovf;
    logic                r_unf;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_is_call;
    logic                w_is_ret;

    assign w_pc_inc  = r_pc + PC_WIDTH'(INC_STEP);
    assign w_is_call = (op == OP_CALL);
    assign w_is_ret  = (op == OP_RET);

    ret_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (en && w_is_call),
        .pop   (en && w_is_ret),
        .din   (w_pc_inc),
        .top   (ret_addr),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        // NOTE: default assignment first so no op value can leave w_pc_next unassigned (no latch).
        w_pc_next = r_pc;
        case (op)
            OP_INC:          w_pc_next = w_pc_inc;
            OP_JMP, OP_CALL: w_pc_next = target;
            OP_BR_REL:       w_pc_next = r_pc + offset;  // modulo add == sign-extended add
            OP_RET:          w_pc_next = stk_empty ? w_pc_inc : ret_addr;
            OP_HOLD:         w_pc_next = r_pc;
            default:         w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= PC_WIDTH'(RESET_VECTOR);
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (en) begin
            r_pc <= w_pc_next;
            // NOTE: non-blocking; the later set below overrides the clear when both happen.
            if (err_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (w_is_call && stk_full) r_ovf <= 1'b1;
            if (w_is_ret && stk_empty) r_unf <= 1'b1;
        end
    end

    assign pc      = r_pc;
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: the driver queues hand-computed post-edge state, a monitor pops and compares.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [7:0] target;
    logic [7:0] offset;
    logic       err_clr;
    logic [7:0] pc;
    logic [7:0] ret_addr;
    logic [2:0] sp;
    logic       stk_full;
    logic       stk_empty;
    logic       ovf_err;
    logic       unf_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic [2:0] sp;
        logic [7:0] ra;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .err_clr   (err_clr),
        .pc        (pc),
        .ret_addr  (ret_addr),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next rising edge.
    task automatic step(input string nm, input logic r, input logic e, input logic [2:0] o,
                        input logic [7:0] t, input logic [7:0] off, input logic clr,
                        input logic [7:0] e_pc, input logic [2:0] e_sp, input logic [7:0] e_ra,
                        input logic e_ovf, input logic e_unf);
        exp_t x;
        @(negedge clk);
        rst     = r;
        en      = e;
        op      = o;
        target  = t;
        offset  = off;
        err_clr = clr;
        x.name = nm; x.pc = e_pc; x.sp = e_sp; x.ra = e_ra; x.ovf = e_ovf; x.unf = e_unf;
        sb.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle after the edge; compare against the queue head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check({x.name, ".pc"},        32'(pc),        32'(x.pc));
                check({x.name, ".sp"},        32'(sp),        32'(x.sp));
                check({x.name, ".ret_addr"},  32'(ret_addr),  32'(x.ra));
                check({x.name, ".stk_full"},  32'(stk_full),  32'(x.sp == 3'd4));
                check({x.name, ".stk_empty"}, 32'(stk_empty), 32'(x.sp == 3'd0));
                check({x.name, ".ovf_err"},   32'(ovf_err),   32'(x.ovf));
                check({x.name, ".unf_err"},   32'(unf_err),   32'(x.unf));
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; op = OP_HOLD; target = '0; offset = '0; err_clr = 1'b0;

        //   name          rst   en    op         tgt    off    clr   pc     sp    ra     ovf   unf
        step("reset",      1'b1, 1'b0, OP_HOLD,   8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        step("inc1",       1'b0, 1'b1, OP_INC,    8'h00, 8'h00, 1'b0, 8'h01, 3'd0, 8'h00, 1'b0, 1'b0);
        step("inc2",       1'b0, 1'b1, OP_INC,    8'h00, 8'h00, 1'b0, 8'h02, 3'd0, 8'h00, 1'b0, 1'b0);
        step("inc3",       1'b0, 1'b1, OP_INC,    8'h00, 8'h00, 1'b0, 8'h03, 3'd0, 8'h00, 1'b0, 1'b0);
        // Jump near the top and wrap silently
        step("jmp_fe",     1'b0, 1'b1, OP_JMP,    8'hFE, 8'h00, 1'b0, 8'hFE, 3'd0, 8'h00, 1'b0, 1'b0);
        step("wrap_ff",    1'b0, 1'b1, OP_INC,    8'h00, 8'h00, 1'b0, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0);
        step("wrap_00",    1'b0, 1'b1, OP_INC,    8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        step("wrap_01",    1'b0, 1'b1, OP_INC,    8'h00, 8'h00, 1'b0, 8'h01, 3'd0, 8'h00, 1'b0, 1'b0);
        step("jmp_10",     1'b0, 1'b1, OP_JMP,    8'h10, 8'h00, 1'b0, 8'h10, 3'd0, 8'h00, 1'b0, 1'b0);
        step("br_back3",   1'b0, 1'b1, OP_BR_REL, 8'h00, 8'hFD, 1'b0, 8'h0D, 3'd0, 8'h00, 1'b0, 1'b0);
        // Nested CALL/RET
        step("jmp_20",     1'b0, 1'b1, OP_JMP,    8'h20, 8'h00, 1'b0, 8'h20, 3'd0, 8'h00, 1'b0, 1'b0);
        step("call_80",    1'b0, 1'b1, OP_CALL,   8'h80, 8'h00, 1'b0, 8'h80, 3'd1, 8'h21, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            step("inc_sub",  1'b0, 1'b1, OP_INC,  8'h00, 8'h00, 1'b0, 8'(8'h80 + i), 3'd1, 8'h21, 1'b0, 1'b0);
        step("call_90",    1'b0, 1'b1, OP_CALL,   8'h90, 8'h00, 1'b0, 8'h90, 3'd2, 8'h86, 1'b0, 1'b0);
        step("ret_86",     1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h86, 3'd1, 8'h21, 1'b0, 1'b0);
        step("ret_21",     1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h21, 3'd0, 8'h00, 1'b0, 1'b0);
        // Fill, overflow, drain in LIFO order, underflow
        step("fill1",      1'b0, 1'b1, OP_CALL,   8'h40, 8'h00, 1'b0, 8'h40, 3'd1, 8'h22, 1'b0, 1'b0);
        step("fill2",      1'b0, 1'b1, OP_CALL,   8'h50, 8'h00, 1'b0, 8'h50, 3'd2, 8'h41, 1'b0, 1'b0);
        step("fill3",      1'b0, 1'b1, OP_CALL,   8'h60, 8'h00, 1'b0, 8'h60, 3'd3, 8'h51, 1'b0, 1'b0);
        step("fill4",      1'b0, 1'b1, OP_CALL,   8'h70, 8'h00, 1'b0, 8'h70, 3'd4, 8'h61, 1'b0, 1'b0);
        step("call_ovf",   1'b0, 1'b1, OP_CALL,   8'hA0, 8'h00, 1'b0, 8'hA0, 3'd4, 8'h61, 1'b1, 1'b0);
        step("drain1",     1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h61, 3'd3, 8'h51, 1'b1, 1'b0);
        step("drain2",     1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h51, 3'd2, 8'h41, 1'b1, 1'b0);
        step("drain3",     1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h41, 3'd1, 8'h22, 1'b1, 1'b0);
        step("drain4",     1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h22, 3'd0, 8'h00, 1'b1, 1'b0);
        step("ret_unf",    1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b0, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        step("hold",       1'b0, 1'b1, OP_HOLD,   8'h00, 8'h00, 1'b0, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        step("reserved",   1'b0, 1'b1, 3'b110,    8'h99, 8'h05, 1'b0, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        // Stall: nothing changes, err_clr ignored
        step("stall_call", 1'b0, 1'b0, OP_CALL,   8'h00, 8'h00, 1'b0, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        step("stall_ret",  1'b0, 1'b0, OP_RET,    8'h00, 8'h00, 1'b0, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        step("stall_jmp",  1'b0, 1'b0, OP_JMP,    8'h77, 8'h00, 1'b0, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        step("stall_clr",  1'b0, 1'b0, OP_HOLD,   8'h00, 8'h00, 1'b1, 8'h23, 3'd0, 8'h00, 1'b1, 1'b1);
        step("call_30",    1'b0, 1'b1, OP_CALL,   8'h30, 8'h00, 1'b0, 8'h30, 3'd1, 8'h24, 1'b1, 1'b1);
        step("stall_c2",   1'b0, 1'b0, OP_CALL,   8'h55, 8'h00, 1'b0, 8'h30, 3'd1, 8'h24, 1'b1, 1'b1);
        step("stall_r2",   1'b0, 1'b0, OP_RET,    8'h00, 8'h00, 1'b0, 8'h30, 3'd1, 8'h24, 1'b1, 1'b1);
        step("err_clr",    1'b0, 1'b1, OP_HOLD,   8'h00, 8'h00, 1'b1, 8'h30, 3'd1, 8'h24, 1'b0, 1'b0);
        // Reset overrides a CALL; then error beats a simultaneous clear
        step("call_90b",   1'b0, 1'b1, OP_CALL,   8'h90, 8'h00, 1'b0, 8'h90, 3'd2, 8'h31, 1'b0, 1'b0);
        step("rst_call",   1'b1, 1'b1, OP_CALL,   8'hA0, 8'h00, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        step("unf_vs_clr", 1'b0, 1'b1, OP_RET,    8'h00, 8'h00, 1'b1, 8'h01, 3'd0, 8'h00, 1'b0, 1'b1);
        step("br_fwd5",    1'b0, 1'b1, OP_BR_REL, 8'h00, 8'h05, 1'b0, 8'h06, 3'd0, 8'h00, 1'b0, 1'b1);

        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
